// File: rtl/store_pkg.sv
// store_pkg: shared state encoding, store funct3 codes and misalignment helper (feature macro STORE_MISALIGNED_SPLIT_EN)
package store_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;
   localparam logic [2:0] F3_SD = 3'b011;

`ifdef STORE_MISALIGNED_SPLIT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1} st_state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_BEAT0} st_state_t;
`endif

   // A store crosses a word boundary when its last byte lands past the word
   function automatic logic is_misaligned(input int unsigned offset, input int unsigned size, input int unsigned nb);
      return (offset + size) > nb;
   endfunction

endpackage

// File: rtl/store_align.sv
// store_align: double-width lane shift, byte-enable mask and legality decode for one store
module store_align
   import store_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int NB = XLEN / 8,
   localparam int OW = $clog2(NB)
) (
   input  logic [2:0]        funct3,
   input  logic [OW-1:0]     offset,
   input  logic [XLEN-1:0]   store_data,
   output logic [2*NB-1:0]   be2,
   output logic [2*XLEN-1:0] wd2,
   output logic              illegal,
   output logic              misaligned
);

   logic [3:0] size;

   assign size       = 4'd1 << funct3[1:0];
   assign be2        = (2*NB)'((9'd1 << size) - 9'd1) << offset;
   assign wd2        = {{XLEN{1'b0}}, store_data} << {offset, 3'b000};
   assign illegal    = funct3[2] || (XLEN == 32 && funct3[1:0] == 2'b11);
   assign misaligned = is_misaligned(32'(offset), 32'(size), NB);

endmodule

// File: rtl/store_unit.sv
// store_unit: MEM-stage store path driving a word-aligned write port, optional misaligned split (STORE_MISALIGNED_SPLIT_EN)
module store_unit
   import store_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   store_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_be,
   output logic              busy,
   output logic              store_fault
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   st_state_t         state_q, state_d;
   logic              mem_valid_q, mem_valid_d;
   logic              fault_q, fault_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [NB-1:0]     mem_be_q, mem_be_d;
   logic [2*NB-1:0]   be2;
   logic [2*XLEN-1:0] wd2;
   logic              illegal, misaligned, final_ok, accept, bad;

`ifdef STORE_MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
   logic              mis_q, mis_d;
   logic [XLEN-1:0]   hi_wdata_q, hi_wdata_d;
   logic [NB-1:0]     hi_be_q, hi_be_d;
   assign final_ok = mem_ready && ((state_q == ST_BEAT0 && !mis_q) || state_q == ST_BEAT1);
`else
   localparam bit SPLIT = 1'b0;
   logic              unused_hi;
   assign unused_hi = ^{be2[2*NB-1:NB], wd2[2*XLEN-1:XLEN]};
   assign final_ok  = mem_ready && state_q == ST_BEAT0;
`endif

   store_align #(.XLEN(XLEN)) u_align (
      .funct3     (funct3),
      .offset     (addr[OW-1:0]),
      .store_data (store_data),
      .be2        (be2),
      .wd2        (wd2),
      .illegal    (illegal),
      .misaligned (misaligned)
   );

   assign req_ready   = state_q == ST_IDLE || final_ok;
   assign accept      = req_valid && req_ready;
   assign bad         = illegal || (misaligned && !SPLIT);
   assign mem_valid   = mem_valid_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;
   assign busy        = state_q != ST_IDLE;
   assign store_fault = fault_q;

   // Next beat: a new accepted store wins, then the second half of a split, then retire
   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      fault_d     = accept && bad;
`ifdef STORE_MISALIGNED_SPLIT_EN
      mis_d       = mis_q;
      hi_wdata_d  = hi_wdata_q;
      hi_be_d     = hi_be_q;
`endif
      if (accept && !bad) begin
         state_d     = ST_BEAT0;
         mem_valid_d = 1'b1;
         mem_addr_d  = {addr[ADDR_W-1:OW], {OW{1'b0}}};
         mem_wdata_d = wd2[XLEN-1:0];
         mem_be_d    = be2[NB-1:0];
`ifdef STORE_MISALIGNED_SPLIT_EN
         mis_d       = misaligned;
         hi_wdata_d  = wd2[2*XLEN-1:XLEN];
         hi_be_d     = be2[2*NB-1:NB];
`endif
      end
`ifdef STORE_MISALIGNED_SPLIT_EN
      else if (state_q == ST_BEAT0 && mis_q && mem_ready) begin
         state_d     = ST_BEAT1;
         mem_addr_d  = mem_addr_q + ADDR_W'(NB);
         mem_wdata_d = hi_wdata_q;
         mem_be_d    = hi_be_q;
      end
`endif
      else if (final_ok) begin
         state_d     = ST_IDLE;
         mem_valid_d = 1'b0;
      end
   end

   // State and registered write-port outputs; reset drops any pending beat
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         fault_q     <= 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
         mis_q       <= 1'b0;
         hi_wdata_q  <= '0;
         hi_be_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         fault_q     <= fault_d;
`ifdef STORE_MISALIGNED_SPLIT_EN
         mis_q       <= mis_d;
         hi_wdata_q  <= hi_wdata_d;
         hi_be_q     <= hi_be_d;
`endif
      end
   end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side data path for the RV32I/RV64I MEM stage: the store counterpart of the load extender.
- Accepts one store request (funct3, byte address, register data) from the pipeline and drives a word-aligned data-memory write port.
- Produces lane-shifted write data and a byte-enable mask for each write.
- Splits word-crossing (misaligned) stores into two sequential memory beats under a valid/ready handshake. Stalls the pipeline via req_ready while busy.

Parameters:
- XLEN, 32, datapath width (32 or 64); NB = XLEN/8 bytes per memory word.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- funct3  in  3  store type: 000 sb, 001 sh, 010 sw, 011 sd (XLEN=64 only).
- addr  in  ADDR_W  store byte address.
- store_data  in  XLEN  rs2 value, LSB-justified.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  ADDR_W  word-aligned address (low log2(NB) bits zero).
- mem_wdata  out  XLEN  lane-aligned write data.
- mem_be  out  NB  byte enables.
- busy  out  1  FSM not IDLE.
- store_fault  out  1  one-cycle pulse: illegal funct3, or misaligned store when splitting is disabled.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, busy=0, store_fault=0. All outputs are registered.
- Size and offset: size = 1 << funct3[1:0]; offset = addr[log2(NB)-1:0].
- Illegal funct3: funct3[2]=1, or 011 when XLEN=32.
- Masks are computed at 2*NB / 2*XLEN width:
  - be2 = ((1<<size)-1) << offset
  - wd2 = zero-extended store_data << (offset*8)
- Beat split: the low halves form beat0; the high halves form beat1. The store is misaligned iff offset+size > NB.
- FSM states: IDLE, BEAT0, BEAT1.
- IDLE:
  - req_ready=1.
  - On accept of a legal store, load beat0 registers (mem_addr = addr with low bits cleared); mem_valid=1 on the next cycle; go to BEAT0.
  - On accept of an illegal store, pulse store_fault next cycle, issue no write, remain IDLE.
- BEAT0: hold mem_addr/mem_wdata/mem_be stable while mem_valid && !mem_ready. On mem_ready:
  - If misaligned, load beat1 (mem_addr += NB, modulo 2^ADDR_W wrap) and go to BEAT1.
  - Otherwise the beat is final.
- BEAT1: hold until mem_ready; this beat is final.
- Final beat accepted: req_ready=1 in that same cycle (combinational on mem_ready), so back-to-back aligned stores sustain one store per cycle.
  - If a new request is accepted simultaneously, load its beat0 with no bubble.
  - Otherwise deassert mem_valid and return to IDLE.
- req_ready=0 in BEAT0 (misaligned) and BEAT1 until the final beat is accepted.
- Reset mid-operation: any pending beat is dropped; mem_valid=0 on the cycle after reset; no partial second beat is issued.
- Request fields are sampled only on acceptance; changes while not ready are ignored.

Optional Feature:
- Macro STORE_MISALIGNED_SPLIT_EN.
- Defined: misaligned stores are split as above.
- Undefined: a misaligned store pulses store_fault, issues no write and keeps the FSM in IDLE. The BEAT1 state and upper-half registers are compiled out.

Decomposition:
- Package store_pkg holds:
  - state enum st_state_t.
  - funct3 localparams F3_SB/F3_SH/F3_SW/F3_SD.
  - a function computing the misaligned flag.
- One combinational sub-module, store_align: inputs funct3, offset, store_data; outputs be2, wd2, illegal, misaligned. The FSM and registers stay in store_unit.

Test Plan:
- XLEN=32, sb addr 0x1003 data 0xDEADBEAB, mem_ready=1 -> one beat: mem_addr 0x1000, mem_be 4'b1000, mem_wdata 0xAB000000; req_ready high throughout.
- sh addr 0x2002 data 0x0000CAFE -> mem_addr 0x2000, be 4'b1100, wdata 0xCAFE0000. Hold mem_ready=0 for 3 cycles -> outputs stable, req_ready=0.
- sw addr 0x1002 data 0x11223344 (split enabled):
  - beat0: addr 0x1000, be 4'b1100, wdata 0x33440000.
  - beat1: addr 0x1004, be 4'b0011, wdata 0x00001122.
  - req_ready=0 until beat1 is accepted.
- Same sw with macro undefined -> store_fault pulses one cycle, mem_valid stays 0.
- Four back-to-back aligned sw to 0x0,0x4,0x8,0xC with mem_ready=1 -> four consecutive beats, no bubbles. Then funct3=011 (XLEN=32) -> store_fault, no write.
- Misaligned sw at 0xFFFFFFFE -> beat1 mem_addr 0x00000000 (wrap). Assert reset during BEAT1 -> mem_valid=0 next cycle, FSM IDLE, no further beat.
